// File: rtl/binary_divider.sv
// binary_divider
// Sequential restoring divider: unsigned WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock. Companion to the shift-and-add multiplier and uses
// the same start/done handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        division request, only looked at while idle
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         high while quotient bits are being developed
//   done         one-cycle pulse, results valid
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (dividend on divide by zero)
//   div_by_zero  registered flag, last accepted operation had divisor 0

module binary_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t state;
   state_t state_next;

   // The partial remainder always stays below the divisor between steps, so
   // its top bit is never set; only WIDTH bits are kept in the register.
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] dvs_reg;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;

   // One restoring step. Because rem_reg < divisor, trial is at most
   // 2*divisor-1: when trial >= divisor the difference is below divisor and
   // its MSB is clear, otherwise the subtraction wraps and the MSB is set.
   // The MSB of the difference is therefore the "does not fit" flag.
   always_comb begin
      trial    = {rem_reg, quo_reg[WIDTH-1]};
      diff     = trial - {1'b0, dvs_reg};
      fits     = ~diff[WIDTH];
      rem_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_step = {quo_reg[WIDTH-2:0], fits};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status outputs. Unused encodings fall back to IDLE.
   always_comb begin
      state_next = IDLE;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (divisor == '0) ? DONE : CALC;
            end else begin
               state_next = IDLE;
            end
         end
         CALC: begin
            busy       = 1'b1;
            state_next = (count == LAST) ? DONE : CALC;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and result registers. Results only change on an accepted start
   // (divide by zero) or on the final step, so they hold between operations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_reg     <= '0;
         quo_reg     <= '0;
         dvs_reg     <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor != '0) begin
                     rem_reg     <= '0;
                     quo_reg     <= dividend;
                     dvs_reg     <= divisor;
                     count       <= '0;
                     div_by_zero <= 1'b0;
                  end else begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            CALC: begin
               rem_reg <= rem_step;
               quo_reg <= quo_step;
               count   <= count + 1'b1;
               if (count == LAST) begin
                  quotient  <= quo_step;
                  remainder <= rem_step;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_binary_divider.sv
// tb_binary_divider
// Drives a WIDTH=4 and a WIDTH=8 divider. A transaction-level model (plain
// integer division plus a cycles-until-idle countdown) predicts busy, done,
// results and the zero flag, and one compare process checks every cycle.
// Directed operations also pin the model with hand-computed values.

module tb_binary_divider;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   logic        stA  [2];
   logic [15:0] opA  [2];
   logic [15:0] opB  [2];

   logic [3:0]  q4, r4;
   logic [7:0]  q8, r8;
   logic        busy4, done4, dbz4;
   logic        busy8, done8, dbz8;

   logic        busyO [2];
   logic        doneO [2];
   logic        dbzO  [2];
   logic [15:0] qO    [2];
   logic [15:0] rO    [2];

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   // Model state: cycles left until the instance is idle again, and the
   // results the last accepted operation must produce.
   int left   [2];
   int expQ   [2];
   int expR   [2];
   bit expDbz [2];

   binary_divider #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(stA[0]),
      .dividend(opA[0][3:0]), .divisor(opB[0][3:0]),
      .busy(busy4), .done(done4),
      .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
   );

   binary_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(stA[1]),
      .dividend(opA[1][7:0]), .divisor(opB[1][7:0]),
      .busy(busy8), .done(done8),
      .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
   );

   always_comb begin
      busyO[0] = busy4;  doneO[0] = done4;  dbzO[0] = dbz4;
      qO[0]    = {12'b0, q4};
      rO[0]    = {12'b0, r4};
      busyO[1] = busy8;  doneO[1] = done8;  dbzO[1] = dbz8;
      qO[1]    = {8'b0, q8};
      rO[1]    = {8'b0, r8};
   end

   function automatic int widthOf(input int k);
      return (k == 0) ? 4 : 8;
   endfunction

   function automatic int maskOf(input int k);
      return (1 << widthOf(k)) - 1;
   endfunction

   task automatic checkOutput(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   // Reference model. A nonzero divide keeps the unit busy for WIDTH cycles
   // and then shows done for one; a zero divisor shows done immediately.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            left[k]   <= 0;
            expQ[k]   <= 0;
            expR[k]   <= 0;
            expDbz[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (left[k] > 0) begin
               left[k] <= left[k] - 1;
            end else if (stA[k]) begin
               if (opB[k] == 16'd0) begin
                  left[k]   <= 1;
                  expQ[k]   <= maskOf(k);
                  expR[k]   <= int'(opA[k]);
                  expDbz[k] <= 1'b1;
               end else begin
                  left[k]   <= widthOf(k) + 1;
                  expQ[k]   <= int'(opA[k]) / int'(opB[k]);
                  expR[k]   <= int'(opA[k]) % int'(opB[k]);
                  expDbz[k] <= 1'b0;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model. Results are compared whenever
   // they are defined: in the done cycle and while idle (held values).
   always @(negedge clk) begin
      if (checking) begin
         for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("w%0d_busy", widthOf(k)), int'(busyO[k]), (left[k] > 1) ? 1 : 0);
            checkOutput($sformatf("w%0d_done", widthOf(k)), int'(doneO[k]), (left[k] == 1) ? 1 : 0);
            checkOutput($sformatf("w%0d_dbz", widthOf(k)), int'(dbzO[k]), int'(expDbz[k]));
            if (left[k] <= 1) begin
               checkOutput($sformatf("w%0d_quotient", widthOf(k)), int'(qO[k]), expQ[k]);
               checkOutput($sformatf("w%0d_remainder", widthOf(k)), int'(rO[k]), expR[k]);
            end
         end
      end
   end

   // Issue one division on instance k (must be idle) and wait for its done.
   // With noisy set, start and operands are scrambled while the unit works.
   // Latency is counted inclusive of the accepting edge.
   task automatic applyStimulus(input int k, input int a, input int b, input bit noisy);
      int edges;
      int busyCycles;
      @(negedge clk);
      stA[k] = 1'b1;
      opA[k] = 16'(a);
      opB[k] = 16'(b);
      @(negedge clk);
      stA[k]     = 1'b0;
      edges      = 1;
      busyCycles = 0;
      while (!doneO[k] && edges < 40) begin
         if (busyO[k]) busyCycles++;
         if (noisy) begin
            stA[k] = 1'($urandom_range(0, 1));
            opA[k] = 16'($urandom & maskOf(k));
            opB[k] = 16'($urandom & maskOf(k));
         end
         @(negedge clk);
         edges++;
      end
      stA[k] = 1'b0;
      checkOutput("done_seen", int'(doneO[k]), 1);
      checkOutput("latency", edges, (b == 0) ? 1 : widthOf(k) + 1);
      checkOutput("busy_cycles", busyCycles, (b == 0) ? 0 : widthOf(k));
      if (b != 0) begin
         checkOutput("invariant", int'(qO[k]) * b + int'(rO[k]), a);
         checkOutput("rem_below_div", (int'(rO[k]) < b) ? 1 : 0, 1);
      end else begin
         checkOutput("dbz_quotient", int'(qO[k]), maskOf(k));
         checkOutput("dbz_remainder", int'(rO[k]), a);
      end
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dones;
      int n;
      for (int k = 0; k < 2; k++) begin
         stA[k] = 1'b0;
         opA[k] = 16'd0;
         opB[k] = 16'd0;
      end
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_busy", int'(busyO[0]), 0);
      checkOutput("reset_done", int'(doneO[0]), 0);
      checkOutput("reset_quotient", int'(qO[0]), 0);
      checkOutput("reset_remainder", int'(rO[0]), 0);
      checkOutput("reset_dbz", int'(dbzO[1]), 0);
      rst = 1'b0;
      checking = 1'b1;

      // Basic division, pinned by hand.
      applyStimulus(0, 13, 4, 1'b0);
      checkOutput("basic_q", int'(qO[0]), 3);
      checkOutput("basic_r", int'(rO[0]), 1);
      checkOutput("basic_dbz", int'(dbzO[0]), 0);

      // Back-to-back edge cases.
      applyStimulus(0, 15, 1, 1'b0);
      checkOutput("15div1_q", int'(qO[0]), 15);
      checkOutput("15div1_r", int'(rO[0]), 0);
      applyStimulus(0, 3, 7, 1'b0);
      checkOutput("3div7_q", int'(qO[0]), 0);
      checkOutput("3div7_r", int'(rO[0]), 3);
      applyStimulus(0, 15, 15, 1'b0);
      checkOutput("15div15_q", int'(qO[0]), 1);
      checkOutput("15div15_r", int'(rO[0]), 0);
      applyStimulus(0, 0, 5, 1'b0);
      checkOutput("0div5_q", int'(qO[0]), 0);
      checkOutput("0div5_r", int'(rO[0]), 0);

      // Divide by zero, then a normal divide clears the flag.
      applyStimulus(0, 9, 0, 1'b0);
      checkOutput("9div0_q", int'(qO[0]), 15);
      checkOutput("9div0_r", int'(rO[0]), 9);
      checkOutput("9div0_dbz", int'(dbzO[0]), 1);
      applyStimulus(0, 8, 2, 1'b0);
      checkOutput("8div2_q", int'(qO[0]), 4);
      checkOutput("8div2_r", int'(rO[0]), 0);
      checkOutput("8div2_dbz", int'(dbzO[0]), 0);

      // Start pulses while busy and during done are ignored.
      @(negedge clk);
      stA[0] = 1'b1; opA[0] = 16'd13; opB[0] = 16'd4;
      @(negedge clk);
      stA[0] = 1'b0;
      @(negedge clk);
      stA[0] = 1'b1; opA[0] = 16'd2; opB[0] = 16'd1;
      @(negedge clk);
      stA[0] = 1'b0; opA[0] = 16'd9; opB[0] = 16'd9;
      n = 0;
      while (!doneO[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ignore_first_done", int'(doneO[0]), 1);
      stA[0] = 1'b1; opA[0] = 16'd5; opB[0] = 16'd1;
      @(negedge clk);
      stA[0] = 1'b0;
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (doneO[0]) dones++;
      end
      checkOutput("ignore_no_second_done", dones, 0);
      checkOutput("ignore_q", int'(qO[0]), 3);
      checkOutput("ignore_r", int'(rO[0]), 1);

      // Reset two cycles into an operation; start held through the release.
      @(negedge clk);
      stA[0] = 1'b1; opA[0] = 16'd7; opB[0] = 16'd2;
      @(negedge clk);
      stA[0] = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_busy", int'(busyO[0]), 0);
      checkOutput("midrst_done", int'(doneO[0]), 0);
      checkOutput("midrst_q", int'(qO[0]), 0);
      checkOutput("midrst_r", int'(rO[0]), 0);
      checkOutput("midrst_dbz", int'(dbzO[0]), 0);
      stA[0] = 1'b1; opA[0] = 16'd11; opB[0] = 16'd5;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      stA[0] = 1'b0;
      applyStimulus(0, 10, 3, 1'b0);
      checkOutput("after_rst_q", int'(qO[0]), 3);
      checkOutput("after_rst_r", int'(rO[0]), 1);

      // Start held high: one result every WIDTH+2 cycles.
      @(negedge clk);
      stA[0] = 1'b1; opA[0] = 16'd14; opB[0] = 16'd3;
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (doneO[0]) dones++;
      end
      stA[0] = 1'b0;
      checkOutput("held_start_dones", dones, 3);
      repeat (8) @(negedge clk);

      // Every WIDTH=4 operand pair.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            applyStimulus(0, a, b, 1'b0);
         end
      end

      // Random WIDTH=8 pairs with input noise while busy.
      for (int i = 0; i < 1000; i++) begin
         int ra;
         int rb;
         ra = int'($urandom & 32'hFF);
         rb = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom & 32'hFF);
         applyStimulus(1, ra, rb, 1'b1);
      end

      repeat (4) @(negedge clk);
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
